// File: rtl/shell_launcher.sv
// -----------------------------------------------------------------------------
// shell_launcher
//
// Projectile controller for the tank game. On a fire request it launches a
// shell from the shooter's world position along the shooter's heading, moves
// it one world unit per tick, and emits a one-cycle tank_hit pulse when the
// shell overlaps the target tank. After a hit it waits for the target to
// respawn (target_reset) or for a lockout timeout before accepting a new fire.
// It also produces a registered per-pixel overlay flag for the shell, using
// the same 8x (column) / 6x (row) world-to-pixel scaling as the icon path.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   fire           launch request, level-sampled in IDLE only
//   tick           one-cycle movement strobe (one per video frame)
//   ShootX_reg     shooter world X
//   ShootY_reg     shooter world Y
//   ShootInfo_reg  shooter BotInfo; [2:0] is the heading
//   TgtX_reg       target world X
//   TgtY_reg       target world Y
//   target_reset   target icon's tank_reset (respawn indication)
//   pixel_column   current display column
//   pixel_row      current display row
//   tank_hit       one-cycle hit pulse to the target icon (registered)
//   busy           high whenever the launcher is not IDLE (registered)
//   shell_x        shell world X
//   shell_y        shell world Y
//   shell_flag     high when the previous cycle's pixel lay inside the shell
// -----------------------------------------------------------------------------
module shell_launcher #(
  parameter logic [31:0] LOCKOUT_MAX = 32'h03FF_FFFF,
  parameter int          SHELL_SIZE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fire,
  input  logic        tick,
  input  logic [7:0]  ShootX_reg,
  input  logic [7:0]  ShootY_reg,
  input  logic [7:0]  ShootInfo_reg,
  input  logic [7:0]  TgtX_reg,
  input  logic [7:0]  TgtY_reg,
  input  logic        target_reset,
  input  logic [11:0] pixel_column,
  input  logic [11:0] pixel_row,
  output logic        tank_hit,
  output logic        busy,
  output logic [7:0]  shell_x,
  output logic [7:0]  shell_y,
  output logic        shell_flag
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLIGHT  = 2'd1,
    ST_HIT     = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  localparam logic [2:0] HEAD_N = 3'b000;
  localparam logic [2:0] HEAD_E = 3'b010;
  localparam logic [2:0] HEAD_S = 3'b100;
  localparam logic [2:0] HEAD_W = 3'b110;

  localparam logic [11:0] SIZE_PX = 12'(SHELL_SIZE);

  state_t      state_q, state_d;
  logic [2:0]  heading_q, heading_d;
  logic [7:0]  shell_x_q, shell_x_d;
  logic [7:0]  shell_y_q, shell_y_d;
  logic [31:0] lock_cnt_q, lock_cnt_d;
  logic        tank_hit_q, tank_hit_d;
  logic        busy_q, busy_d;
  logic        shell_flag_q, shell_flag_d;

  // ---------------------------------------------------------------------------
  // Step candidate: 9-bit signed so a step off either edge of 0..127 is
  // detectable instead of wrapping.
  // ---------------------------------------------------------------------------
  logic signed [8:0] step_x, step_y;
  logic              step_oob;

  always_comb begin
    step_x = $signed({1'b0, shell_x_q});
    step_y = $signed({1'b0, shell_y_q});
    case (heading_q)
      HEAD_N:  step_y = $signed({1'b0, shell_y_q}) - 9'sd1;
      HEAD_E:  step_x = $signed({1'b0, shell_x_q}) + 9'sd1;
      HEAD_S:  step_y = $signed({1'b0, shell_y_q}) + 9'sd1;
      HEAD_W:  step_x = $signed({1'b0, shell_x_q}) - 9'sd1;
      default: ;
    endcase
    step_oob = (step_x < 9'sd0) || (step_x > 9'sd127) ||
               (step_y < 9'sd0) || (step_y > 9'sd127);
  end

  // ---------------------------------------------------------------------------
  // Overlap with the target box. Upper bounds are formed in 9 bits so a
  // target at 127 (or above) does not wrap to a small value.
  // ---------------------------------------------------------------------------
  logic [8:0] tgt_x_hi, tgt_y_hi;
  logic       overlap;

  always_comb begin
    tgt_x_hi = {1'b0, TgtX_reg} + 9'd1;
    tgt_y_hi = {1'b0, TgtY_reg} + 9'd2;
    overlap  = (shell_x_q >= TgtX_reg) && ({1'b0, shell_x_q} <= tgt_x_hi) &&
               (shell_y_q >= TgtY_reg) && ({1'b0, shell_y_q} <= tgt_y_hi);
  end

  // ---------------------------------------------------------------------------
  // Overlay box origin: sx = x*8+6, sy = y*6+6 (max 1022, fits in 12 bits).
  // ---------------------------------------------------------------------------
  logic [11:0] org_x, org_y;
  logic        in_box;

  always_comb begin
    org_x  = {1'b0, shell_x_q, 3'b000} + 12'd6;
    org_y  = {2'b00, shell_y_q, 2'b00} + {3'b000, shell_y_q, 1'b0} + 12'd6;
    in_box = (pixel_column >= org_x) && (pixel_column < org_x + SIZE_PX) &&
             (pixel_row    >= org_y) && (pixel_row    < org_y + SIZE_PX);
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    heading_d  = heading_q;
    shell_x_d  = shell_x_q;
    shell_y_d  = shell_y_q;
    lock_cnt_d = lock_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // Only the four cardinal headings launch; diagonals are ignored.
        if (fire && (ShootInfo_reg[2:0] == HEAD_N || ShootInfo_reg[2:0] == HEAD_E ||
                     ShootInfo_reg[2:0] == HEAD_S || ShootInfo_reg[2:0] == HEAD_W)) begin
          shell_x_d = ShootX_reg;
          shell_y_d = ShootY_reg;
          heading_d = ShootInfo_reg[2:0];
          state_d   = ST_FLIGHT;
        end
      end

      ST_FLIGHT: begin
        // Hit wins over everything; a tick in the hit cycle leaves the shell put.
        if (overlap) begin
          state_d = ST_HIT;
        end else if (tick) begin
          if (step_oob) begin
            state_d = ST_IDLE;
          end else begin
            shell_x_d = step_x[7:0];
            shell_y_d = step_y[7:0];
          end
        end
      end

      ST_HIT: begin
        state_d    = ST_LOCKOUT;
        lock_cnt_d = '0;
      end

      ST_LOCKOUT: begin
        // The counter holds the number of lockout cycles already completed;
        // leaving when the next count reaches LOCKOUT_MAX gives exactly
        // LOCKOUT_MAX cycles in this state.
        if (target_reset || (lock_cnt_q + 32'd1 >= LOCKOUT_MAX)) begin
          state_d = ST_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + 32'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    tank_hit_d   = (state_d == ST_HIT);
    busy_d       = (state_d != ST_IDLE);
    shell_flag_d = (state_q == ST_FLIGHT) && in_box;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      heading_q    <= HEAD_N;
      shell_x_q    <= '0;
      shell_y_q    <= '0;
      lock_cnt_q   <= '0;
      tank_hit_q   <= 1'b0;
      busy_q       <= 1'b0;
      shell_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      heading_q    <= heading_d;
      shell_x_q    <= shell_x_d;
      shell_y_q    <= shell_y_d;
      lock_cnt_q   <= lock_cnt_d;
      tank_hit_q   <= tank_hit_d;
      busy_q       <= busy_d;
      shell_flag_q <= shell_flag_d;
    end
  end

  assign tank_hit   = tank_hit_q;
  assign busy       = busy_q;
  assign shell_x    = shell_x_q;
  assign shell_y    = shell_y_q;
  assign shell_flag = shell_flag_q;

endmodule

// File: tb/tb_shell_launcher.sv
// -----------------------------------------------------------------------------
// tb_shell_launcher: directed vectors with hand-computed expected values for
// shell_launcher (LOCKOUT_MAX = 16). Inputs change 1 ns after the rising edge;
// outputs are sampled at the same point, i.e. after the edge has settled.
// -----------------------------------------------------------------------------
module tb_shell_launcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        fire;
  logic        tick;
  logic [7:0]  ShootX_reg, ShootY_reg, ShootInfo_reg;
  logic [7:0]  TgtX_reg, TgtY_reg;
  logic        target_reset;
  logic [11:0] pixel_column, pixel_row;
  logic        tank_hit, busy, shell_flag;
  logic [7:0]  shell_x, shell_y;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shell_launcher #(
    .LOCKOUT_MAX(32'd16),
    .SHELL_SIZE (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fire         (fire),
    .tick         (tick),
    .ShootX_reg   (ShootX_reg),
    .ShootY_reg   (ShootY_reg),
    .ShootInfo_reg(ShootInfo_reg),
    .TgtX_reg     (TgtX_reg),
    .TgtY_reg     (TgtY_reg),
    .target_reset (target_reset),
    .pixel_column (pixel_column),
    .pixel_row    (pixel_row),
    .tank_hit     (tank_hit),
    .busy         (busy),
    .shell_x      (shell_x),
    .shell_y      (shell_y),
    .shell_flag   (shell_flag)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [7:0] sx, input logic [7:0] sy, input logic [7:0] info,
                       input logic [7:0] tx, input logic [7:0] ty);
    ShootX_reg    = sx;
    ShootY_reg    = sy;
    ShootInfo_reg = info;
    TgtX_reg      = tx;
    TgtY_reg      = ty;
  endtask

  initial begin
    int n;
    reset = 1'b1; fire = 1'b0; tick = 1'b0; target_reset = 1'b0;
    pixel_column = '0; pixel_row = '0;
    setup(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    cyc(); cyc();

    // ---------------- reset state ----------------
    chk("rst_busy",  busy, 0);
    chk("rst_hit",   tank_hit, 0);
    chk("rst_sx",    shell_x, 0);
    chk("rst_sy",    shell_y, 0);
    chk("rst_flag",  shell_flag, 0);
    reset = 1'b0;
    cyc();

    // ---------------- fire east, hit at X=15, lockout timeout ----------------
    setup(8'd10, 8'd20, 8'h02, 8'd15, 8'd20);
    fire = 1'b1; cyc(); fire = 1'b0;
    chk("east_busy", busy, 1);
    chk("east_x0",   shell_x, 10);
    chk("east_y0",   shell_y, 20);
    for (int k = 1; k <= 5; k++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      chk($sformatf("east_x%0d", k), shell_x, 32'(10 + k));
      chk($sformatf("east_nohit%0d", k), tank_hit, 0);
      if (k < 5) begin
        cyc(); cyc(); cyc();
      end
    end
    cyc();
    chk("east_hit_pulse", tank_hit, 1);
    chk("east_hit_x",     shell_x, 15);
    cyc();
    chk("east_hit_end",   tank_hit, 0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      cyc();
    end
    chk("lockout_timeout_cycles", n, 16);
    chk("lockout_timeout_hit",    tank_hit, 0);

    // ---------------- immediate hit, target_reset during lockout ----------------
    setup(8'd40, 8'd50, 8'h00, 8'd40, 8'd48);
    fire = 1'b1; cyc(); fire = 1'b0;
    chk("tr_busy",     busy, 1);
    chk("tr_nohit_ld", tank_hit, 0);
    cyc();
    chk("tr_hit",      tank_hit, 1);
    cyc();
    chk("tr_hit_end",  tank_hit, 0);
    repeat (4) cyc();
    chk("tr_busy_c5",  busy, 1);
    target_reset = 1'b1; cyc(); target_reset = 1'b0;
    chk("tr_idle",     busy, 0);

    // ---------------- miss at east wall ----------------
    setup(8'd126, 8'd5, 8'h02, 8'd0, 8'd100);
    fire = 1'b1; cyc(); fire = 1'b0;
    chk("wall_x0", shell_x, 126);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("wall_x1",   shell_x, 127);
    chk("wall_busy", busy, 1);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("wall_idle", busy, 0);
    chk("wall_xend", shell_x, 127);
    chk("wall_nohit", tank_hit, 0);

    // ---------------- illegal heading ----------------
    setup(8'd30, 8'd30, 8'h03, 8'd0, 8'd100);
    fire = 1'b1; cyc();
    chk("illegal_busy1", busy, 0);
    cyc();
    chk("illegal_busy2", busy, 0);
    chk("illegal_x",     shell_x, 127);
    fire = 1'b0;

    // ---------------- fire ignored in flight, heading latched ----------------
    setup(8'd60, 8'd60, 8'h04, 8'd0, 8'd0);
    fire = 1'b1; cyc(); fire = 1'b0;
    ShootInfo_reg = 8'h02; ShootX_reg = 8'd5;
    fire = 1'b1; tick = 1'b1; cyc(); fire = 1'b0; tick = 1'b0;
    chk("latch_x", shell_x, 60);
    chk("latch_y", shell_y, 61);
    chk("latch_busy", busy, 1);

    // ---------------- reset mid-flight with tick high ----------------
    reset = 1'b1; tick = 1'b1; cyc(); reset = 1'b0; tick = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_x",    shell_x, 0);
    chk("midrst_y",    shell_y, 0);
    chk("midrst_hit",  tank_hit, 0);
    chk("midrst_flag", shell_flag, 0);

    // ---------------- relaunch + overlay at (2,3): box cols 22..25 rows 24..27 ----
    setup(8'd2, 8'd3, 8'h00, 8'd100, 8'd100);
    fire = 1'b1; cyc(); fire = 1'b0;
    chk("ovl_busy", busy, 1);
    chk("ovl_x",    shell_x, 2);
    chk("ovl_y",    shell_y, 3);
    pixel_row = 12'd25;
    for (int c = 20; c <= 27; c++) begin
      pixel_column = 12'(c);
      cyc();
      chk($sformatf("ovl_col%0d", c), shell_flag, (c >= 22 && c <= 25) ? 1 : 0);
    end
    pixel_column = 12'd23;
    for (int r = 22; r <= 29; r++) begin
      pixel_row = 12'(r);
      cyc();
      chk($sformatf("ovl_row%0d", r), shell_flag, (r >= 24 && r <= 27) ? 1 : 0);
    end
    // Fly north into the wall: y 3->2->1->0, fourth tick ends the flight.
    for (int k = 1; k <= 4; k++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
    end
    chk("north_idle", busy, 0);
    chk("north_y",    shell_y, 0);
    // Shell now at (2,0): origin (22,6). Pixel inside the box but IDLE.
    pixel_column = 12'd22; pixel_row = 12'd6;
    cyc();
    cyc();
    chk("ovl_idle_flag", shell_flag, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
